// File: rtl/cordic_req_arbiter.sv
// cordic_req_arbiter
// Shares one fully pipelined CORDIC sin/cos core between two requesters.
// A round-robin grant picks at most one angle per cycle and drives it to the
// core. A {valid, id} tag travels alongside through a LATENCY+1 deep shift
// register, so each core result is returned to the requester that issued it,
// in issue order.
//
// Ports
//   CLK_100MHZ, RST_N          clock, asynchronous active-low reset
//   req0_*/req1_*              valid/ready angle requests (2^32 = 360 deg)
//   rsp0_valid/rsp1_valid      one-cycle result strobes, no backpressure
//   rsp_cos/rsp_sin            shared result bus, qualified by rspN_valid
//   cordic_angle/xin/yin       drive the core (xin = X_SEED, yin = 0)
//   cordic_xout/yout           core results, stable LATENCY edges after sampling
module cordic_req_arbiter #(
  parameter int unsigned LATENCY = 16,
  parameter int unsigned MAX_OUT = 8,
  parameter logic [15:0] X_SEED  = 16'd19429
) (
  input  logic        CLK_100MHZ,
  input  logic        RST_N,
  input  logic        req0_valid,
  input  logic [31:0] req0_angle,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_angle,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [16:0] rsp_cos,
  output logic [16:0] rsp_sin,
  output logic [31:0] cordic_angle,
  output logic [15:0] cordic_xin,
  output logic [15:0] cordic_yin,
  input  logic [16:0] cordic_xout,
  input  logic [16:0] cordic_yout
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

  // r_run holds grants off until the first edge after reset release, so no
  // request is accepted on the edge that coincides with the release.
  logic             r_run;
  logic             r_prio;
  logic [3:0]       r_cnt0;
  logic [3:0]       r_cnt1;
  logic [LATENCY:0] r_tag_vld;
  logic [LATENCY:0] r_tag_id;

  logic w_elig0;
  logic w_elig1;
  logic w_grant0;
  logic w_grant1;
  logic w_accept;

  assign w_elig0  = r_run && req0_valid && (r_cnt0 < MAX_CNT);
  assign w_elig1  = r_run && req1_valid && (r_cnt1 < MAX_CNT);
  assign w_grant0 = w_elig0 && (!w_elig1 || !r_prio);
  assign w_grant1 = w_elig1 && (!w_elig0 ||  r_prio);
  assign w_accept = w_grant0 || w_grant1;

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  assign cordic_xin = X_SEED;
  assign cordic_yin = '0;

  always_ff @(posedge CLK_100MHZ or negedge RST_N) begin
    if (!RST_N) begin
      r_run        <= 1'b0;
      r_prio       <= 1'b0;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
      r_tag_vld    <= '0;
      r_tag_id     <= '0;
      cordic_angle <= '0;
      rsp_cos      <= '0;
      rsp_sin      <= '0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
    end else begin
      r_run <= 1'b1;

      if (w_grant0) begin
        cordic_angle <= req0_angle;
      end else if (w_grant1) begin
        cordic_angle <= req1_angle;
      end

      if (w_accept) begin
        r_prio <= w_grant0;
      end

      // Tag id is 1 exactly when requester 1 was granted.
      r_tag_vld <= {r_tag_vld[LATENCY-1:0], w_accept};
      r_tag_id  <= {r_tag_id[LATENCY-1:0],  w_grant1};

      if (r_tag_vld[LATENCY]) begin
        rsp_cos    <= cordic_xout;
        rsp_sin    <= cordic_yout;
        rsp0_valid <= !r_tag_id[LATENCY];
        rsp1_valid <=  r_tag_id[LATENCY];
      end else begin
        rsp0_valid <= 1'b0;
        rsp1_valid <= 1'b0;
      end

      // Credit returns on the edge that ends the response strobe; an accept
      // and a return on the same edge cancel.
      r_cnt0 <= r_cnt0 + {3'b000, w_grant0} - {3'b000, rsp0_valid};
      r_cnt1 <= r_cnt1 + {3'b000, w_grant1} - {3'b000, rsp1_valid};
    end
  end

endmodule
